// File: rtl/sid_link_pkg.sv
// rtl/sid_link_pkg.sv - shared constants and FSM state type for the SID frame decoder
package sid_link_pkg;

   localparam logic [7:0] HDR_DEF = 8'hA5;
   localparam logic [7:0] ACK_DEF = 8'h06;
   localparam logic [7:0] NAK_DEF = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      ADDR,
      DATA,
      CSUM,
      DRAIN,
      RESP
   } state_t;

endpackage

// File: rtl/sid_frame_decoder_if.sv
// rtl/sid_frame_decoder_if.sv - receiver, register-bus and transmitter signals of the SID frame decoder
interface sid_frame_decoder_if #(
   parameter int ADDR_W = 5
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_eop;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_ready;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy;
   logic              frame_err;
   logic              busy;

   modport master (
      output rx_valid, rx_data, rx_eop, wr_ready, tx_busy,
      input  wr_valid, wr_addr, wr_data, tx_start, tx_data, frame_err, busy
   );

   modport slave (
      input  rx_valid, rx_data, rx_eop, wr_ready, tx_busy,
      output wr_valid, wr_addr, wr_data, tx_start, tx_data, frame_err, busy
   );
endinterface

// File: rtl/sid_pair_buf.sv
// rtl/sid_pair_buf.sv - frame buffer of {addr,data} pairs with write/read pointers
module sid_pair_buf #(
   parameter int DEPTH = 16,
   parameter int W     = 13,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          we_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          rinc_i,
   output logic [PW-1:0] wptr_o,
   output logic [PW-1:0] rptr_o,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;

   // Pair storage: one entry written per accepted DATA byte
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // Pointers restart at every new frame; each advances on its own strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clr_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (we_i) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (rinc_i) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   assign wptr_o  = wptr_q;
   assign rptr_o  = rptr_q;
   assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/sid_frame_decoder.sv
// rtl/sid_frame_decoder.sv - parses SID register-write frames, replays them on the register bus, answers ACK/NAK
module sid_frame_decoder
   import sid_link_pkg::*;
#(
   parameter int         DEPTH  = 16,
   parameter int         ADDR_W = 5,
   parameter logic [7:0] HDR    = HDR_DEF,
   parameter logic [7:0] ACK    = ACK_DEF,
   parameter logic [7:0] NAK    = NAK_DEF
) (
   input logic                 clk,
   input logic                 rst,
   sid_frame_decoder_if.slave  bus
);

   localparam int         PW      = $clog2(DEPTH);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t            state_q;
   logic [PW:0]       count_q;
   logic [7:0]        csum_q;
   logic [ADDR_W-1:0] addr_q;
   logic              nak_q;
   logic              wr_valid_q;
   logic              tx_start_q;
   logic [7:0]        tx_data_q;
   logic              frame_err_q;

   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [ADDR_W+7:0] rdata;
   logic [PW:0]       cnt_m1;
   logic              hdr_hit;
   logic              buf_we;
   logic              wr_hs;
   logic              last_w;
   logic              last_r;
   logic              len_bad;
   logic              in_parse;
   logic              byte_ends;
   logic              abort;

   assign hdr_hit   = (state_q == IDLE) && bus.rx_valid && (bus.rx_data == HDR);
   assign buf_we    = (state_q == DATA) && bus.rx_valid;
   assign wr_hs     = wr_valid_q && bus.wr_ready;
   assign cnt_m1    = count_q - (PW+1)'(1);
   assign last_w    = ({1'b0, wptr} == cnt_m1);
   assign last_r    = ({1'b0, rptr} == cnt_m1);
   assign len_bad   = (bus.rx_data == 8'h00) || (bus.rx_data > DEPTH_B);
   assign in_parse  = (state_q == LEN) || (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
   // A byte that already closes the frame wins over an end-of-packet in the same cycle
   assign byte_ends = bus.rx_valid && (((state_q == LEN) && len_bad) || (state_q == CSUM));
   assign abort     = bus.rx_eop && in_parse && !byte_ends;

   sid_pair_buf #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + 8)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (hdr_hit),
      .we_i    (buf_we),
      .wdata_i ({addr_q, bus.rx_data}),
      .rinc_i  (wr_hs),
      .wptr_o  (wptr),
      .rptr_o  (rptr),
      .rdata_o (rdata)
   );

   // Frame FSM: parse, checksum, drain to the register bus, then one response byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         csum_q      <= '0;
         addr_q      <= '0;
         nak_q       <= 1'b0;
         wr_valid_q  <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         tx_start_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hdr_hit) begin
                  csum_q  <= '0;
                  nak_q   <= 1'b0;
                  state_q <= LEN;
               end
            end
            LEN: begin
               if (bus.rx_valid) begin
                  if (len_bad) begin
                     nak_q   <= 1'b1;
                     state_q <= RESP;
                  end else begin
                     count_q <= bus.rx_data[PW:0];
                     csum_q  <= bus.rx_data;
                     state_q <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (bus.rx_valid) begin
                  addr_q  <= bus.rx_data[ADDR_W-1:0];
                  csum_q  <= csum_q ^ bus.rx_data;
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bus.rx_valid) begin
                  csum_q  <= csum_q ^ bus.rx_data;
                  state_q <= last_w ? CSUM : ADDR;
               end
            end
            CSUM: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == csum_q) begin
                     wr_valid_q <= 1'b1;
                     state_q    <= DRAIN;
                  end else begin
                     nak_q   <= 1'b1;
                     state_q <= RESP;
                  end
               end
            end
            DRAIN: begin
               if (wr_hs && last_r) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               if (!bus.tx_busy) begin
                  tx_start_q  <= 1'b1;
                  tx_data_q   <= nak_q ? NAK : ACK;
                  frame_err_q <= nak_q;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (abort) begin
            nak_q   <= 1'b1;
            state_q <= RESP;
         end
      end
   end

   assign bus.wr_valid  = wr_valid_q;
   assign bus.wr_addr   = rdata[ADDR_W+7:8];
   assign bus.wr_data   = rdata[7:0];
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sid_frame_decoder.sv
// tb/tb_sid_frame_decoder.sv - self-checking bench for sid_frame_decoder
module tb_sid_frame_decoder;

   localparam int         DEPTH  = 16;
   localparam int         ADDR_W = 5;
   localparam logic [7:0] HDR    = 8'hA5;
   localparam logic [7:0] ACK    = 8'h06;
   localparam logic [7:0] NAK    = 8'h15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sid_frame_decoder_if #(.ADDR_W(ADDR_W)) bif ();

   sid_frame_decoder #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .HDR    (HDR),
      .ACK    (ACK),
      .NAK    (NAK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   typedef struct {
      logic [0:7][7:0]  b;
      int               n;
      int               eop_mode;
      int               nw;
      logic [0:1][15:0] w;
      logic [7:0]       resp;
   } vec_t;

   vec_t       vt[6];
   int         n_pass = 0;
   int         n_total = 0;
   int         ready_mode = 0;
   int         wr_log[$];
   logic [7:0] resp_log[$];
   logic       ferr_log[$];
   int         exp_w[$];
   logic [7:0] fr[$];
   int         stray_ferr = 0;
   int         dbl_start = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: expected writes and response from the frame byte list alone
   function automatic logic [7:0] model();
      int len, need;
      logic [7:0] x;
      exp_w = {};
      len = int'(fr[1]);
      if (len < 1 || len > DEPTH) return NAK;
      need = 2 * len + 3;
      if (fr.size() < need) return NAK;
      x = 8'h00;
      for (int i = 1; i < need - 1; i++) x = x ^ fr[i];
      if (x != fr[need-1]) return NAK;
      for (int p = 0; p < len; p++)
         exp_w.push_back(((int'(fr[2+2*p]) % (1 << ADDR_W)) << 8) | int'(fr[3+2*p]));
      return ACK;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit eop);
      @(posedge clk); #1;
      bif.rx_valid = 1'b1;
      bif.rx_data  = b;
      bif.rx_eop   = eop;
      @(posedge clk); #1;
      bif.rx_valid = 1'b0;
      bif.rx_eop   = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic send_frame(input int eop_mode);
      for (int i = 0; i < fr.size(); i++) send_byte(fr[i], (eop_mode == 1) && (i == fr.size() - 1));
      if (eop_mode == 2) begin
         @(posedge clk); #1;
         bif.rx_eop = 1'b1;
         @(posedge clk); #1;
         bif.rx_eop = 1'b0;
      end
   endtask

   task automatic finish_frame(input string tag, input logic [7:0] exp_resp);
      for (int c = 0; c < 3000 && resp_log.size() == 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk({tag, ".nwrites"}, wr_log.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) chk({tag, ".write"}, wr_log[i], exp_w[i]);
      chk({tag, ".nresp"}, resp_log.size(), 1);
      if (resp_log.size() > 0) begin
         chk({tag, ".resp"}, int'(resp_log[0]), int'(exp_resp));
         chk({tag, ".frame_err"}, int'(ferr_log[0]), int'(exp_resp == NAK));
      end
      chk({tag, ".idle"}, int'(bif.busy), 0);
      wr_log.delete();
      resp_log.delete();
      ferr_log.delete();
   endtask

   // wr_ready pattern generator
   initial begin
      bif.wr_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bif.wr_ready = 1'b1;
            1:       bif.wr_ready = ~bif.wr_ready;
            2:       bif.wr_ready = 1'($urandom_range(0, 1));
            default: bif.wr_ready = 1'b0;
         endcase
      end
   end

   // Bus monitor: logs handshakes/responses and checks stall stability
   initial begin
      bit   hold_pend = 0;
      int   held = 0;
      logic prev_tx = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pend = 0;
            prev_tx   = 0;
         end else begin
            if (hold_pend) begin
               chk("hold_valid", int'(bif.wr_valid), 1);
               chk("hold_payload", int'({bif.wr_addr, bif.wr_data}), held);
            end
            if (bif.wr_valid && bif.wr_ready) wr_log.push_back(int'({bif.wr_addr, bif.wr_data}));
            if (bif.tx_start) begin
               resp_log.push_back(bif.tx_data);
               ferr_log.push_back(bif.frame_err);
            end else if (bif.frame_err) begin
               stray_ferr++;
            end
            if (prev_tx && bif.tx_start) dbl_start++;
            prev_tx   = bif.tx_start;
            hold_pend = bif.wr_valid && !bif.wr_ready;
            held      = int'({bif.wr_addr, bif.wr_data});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, len, eop_mode;
      logic [7:0] x, b, er;

      vt[0] = '{b: {8'hA5, 8'h02, 8'h04, 8'h11, 8'h18, 8'h0F, 8'h00, 8'h00}, n: 7, eop_mode: 0, nw: 2, w: {16'h0411, 16'h180F}, resp: ACK};
      vt[1] = '{b: {8'hA5, 8'h02, 8'h04, 8'h11, 8'h18, 8'h0F, 8'h01, 8'h00}, n: 7, eop_mode: 0, nw: 0, w: {16'h0, 16'h0}, resp: NAK};
      vt[2] = '{b: {8'hA5, 8'h00, 48'h0}, n: 2, eop_mode: 0, nw: 0, w: {16'h0, 16'h0}, resp: NAK};
      vt[3] = '{b: {8'hA5, 8'h11, 48'h0}, n: 2, eop_mode: 0, nw: 0, w: {16'h0, 16'h0}, resp: NAK};
      vt[4] = '{b: {8'hA5, 8'h02, 8'h04, 8'h11, 32'h0}, n: 4, eop_mode: 2, nw: 0, w: {16'h0, 16'h0}, resp: NAK};
      vt[5] = '{b: {8'hA5, 8'h02, 8'h04, 8'h11, 8'h18, 8'h0F, 8'h00, 8'h00}, n: 7, eop_mode: 1, nw: 2, w: {16'h0411, 16'h180F}, resp: ACK};

      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'h00;
      bif.rx_eop   = 1'b0;
      bif.tx_busy  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.wr_valid", int'(bif.wr_valid), 0);
      chk("rst.tx_start", int'(bif.tx_start), 0);
      chk("rst.frame_err", int'(bif.frame_err), 0);
      chk("rst.busy", int'(bif.busy), 0);
      chk("rst.tx_data", int'(bif.tx_data), 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         ready_mode = 0;
         fr = {};
         for (int k = 0; k < vt[i].n; k++) fr.push_back(vt[i].b[k]);
         exp_w = {};
         for (int k = 0; k < vt[i].nw; k++) exp_w.push_back(int'(vt[i].w[k]));
         send_frame(vt[i].eop_mode);
         finish_frame($sformatf("vec%0d", i), vt[i].resp);
         if (i == 2) begin
            send_byte(8'h11, 1'b0);
            send_byte(8'h22, 1'b0);
            send_byte(8'h33, 1'b1);
            repeat (20) @(negedge clk);
            chk("ignore.writes", wr_log.size(), 0);
            chk("ignore.resp", resp_log.size(), 0);
            chk("ignore.busy", int'(bif.busy), 0);
         end
      end

      // Same good frame with wr_ready toggling every cycle
      ready_mode = 1;
      fr = {8'hA5, 8'h02, 8'h04, 8'h11, 8'h18, 8'h0F, 8'h00};
      exp_w = {32'h0411, 32'h180F};
      send_frame(0);
      finish_frame("toggle", ACK);

      // Transmitter held busy at the response
      ready_mode = 0;
      @(posedge clk); #1;
      bif.tx_busy = 1'b1;
      send_frame(0);
      repeat (100) @(negedge clk);
      chk("txbusy.no_start", resp_log.size(), 0);
      chk("txbusy.busy", int'(bif.busy), 1);
      @(posedge clk); #1;
      bif.tx_busy = 1'b0;
      @(negedge clk);
      chk("txbusy.not_yet", int'(bif.tx_start), 0);
      @(negedge clk);
      chk("txbusy.start", int'(bif.tx_start), 1);
      chk("txbusy.data", int'(bif.tx_data), int'(ACK));
      finish_frame("txbusy", ACK);

      // Asynchronous reset while draining
      ready_mode = 3;
      send_frame(0);
      for (int c = 0; c < 100 && !bif.wr_valid; c++) @(negedge clk);
      chk("rstdrain.valid", int'(bif.wr_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rstdrain.wr_valid", int'(bif.wr_valid), 0);
      chk("rstdrain.busy", int'(bif.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 0;
      repeat (40) @(negedge clk);
      chk("rstdrain.writes", wr_log.size(), 0);
      chk("rstdrain.resp", resp_log.size(), 0);
      wr_log.delete();
      resp_log.delete();
      ferr_log.delete();

      // Randomized frames against the reference model
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 3);
         ready_mode = $urandom_range(0, 2);
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            send_byte(b, 1'b0);
         end
         if (kind == 2) len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DEPTH + 1, 255);
         else len = $urandom_range(1, DEPTH);
         fr = {HDR, 8'(len)};
         if (kind != 2) begin
            x = 8'(len);
            for (int p = 0; p < 2 * len; p++) begin
               b = 8'($urandom_range(0, 255));
               fr.push_back(b);
               x = x ^ b;
            end
            if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
            fr.push_back(x);
         end
         eop_mode = $urandom_range(0, 2);
         if (kind == 3) begin
            int cut;
            cut = $urandom_range(2, fr.size() - 1);
            while (fr.size() > cut) void'(fr.pop_back());
            eop_mode = $urandom_range(1, 2);
         end
         er = model();
         send_frame(eop_mode);
         finish_frame($sformatf("rand%0d", t), er);
      end

      chk("stray_frame_err", stray_ferr, 0);
      chk("double_tx_start", dbl_start, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
